prbs16_checker: RTL

// Receive-side partner of the 16-bit maximal-length LFSR generator (x^16+x^15+x^13+x^4, seed 16'h455F).

---
 rtl/prbs16_checker_if.sv | 39 +++
 rtl/prbs16_checker.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/prbs16_checker_if.sv
// ---------------------------------------------------------------------------
// prbs16_checker_if
// Bundles the receive stream and the status outputs of the PRBS16 checker.
//   master : the stream source / status consumer (drives bit_in, bit_valid,
//            clr_cnt; observes locked, err_pulse, err_count, bit_count,
//            state_out)
//   slave  : the checker itself
// Signals:
//   bit_in     received stream bit, sampled when bit_valid=1
//   bit_valid  qualifies bit_in
//   clr_cnt    synchronous clear of err_count and bit_count
//   locked     1 while the checker is in LOCKED
//   err_pulse  one-cycle pulse per mismatched bit while LOCKED
//   err_count  saturating count of LOCKED mismatches
//   bit_count  saturating count of valid bits checked while LOCKED
//   state_out  00 FILL, 01 VERIFY, 10 LOCKED
// ---------------------------------------------------------------------------
interface prbs16_checker_if #(
    parameter int CNT_W = 16
);
    logic             bit_in;
    logic             bit_valid;
    logic             clr_cnt;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] bit_count;
    logic [1:0]       state_out;

    modport master (
        output bit_in, bit_valid, clr_cnt,
        input  locked, err_pulse, err_count, bit_count, state_out
    );

    modport slave (
        input  bit_in, bit_valid, clr_cnt,
        output locked, err_pulse, err_count, bit_count, state_out
    );
endinterface

// File: rtl/prbs16_checker.sv
// ---------------------------------------------------------------------------
// prbs16_checker
// Receive-side partner of the x^16+x^15+x^13+x^4 PRBS generator. It first
// fills a 16-bit shift register from the stream, then verifies LOCK_CNT
// consecutive predictions, then free-runs its own LFSR (flywheel) and flags
// every received bit that disagrees with it.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous reset, active-low, overrides all other inputs
//   chk    prbs16_checker_if.slave: bit_in/bit_valid/clr_cnt in,
//          locked/err_pulse/err_count/bit_count/state_out out
// Parameters:
//   LOCK_CNT    consecutive correct predictions in VERIFY before lock
//   WINDOW      loss-of-lock observation window, in valid LOCKED bits
//   LOSS_THRESH errors within one window that drop lock (1..WINDOW)
//   CNT_W       width of err_count and bit_count
// ---------------------------------------------------------------------------
module prbs16_checker #(
    parameter int LOCK_CNT    = 32,
    parameter int WINDOW      = 256,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    prbs16_checker_if.slave   chk
);

    localparam int GOOD_W = ($clog2(LOCK_CNT) > 0) ? $clog2(LOCK_CNT) : 1;
    localparam int WIN_W  = ($clog2(WINDOW) > 0) ? $clog2(WINDOW) : 1;
    localparam int WE_W   = $clog2(LOSS_THRESH + 1);

    typedef enum logic [1:0] {
        S_FILL   = 2'b00,
        S_VERIFY = 2'b01,
        S_LOCKED = 2'b10
    } state_e;

    state_e           state_q;
    logic [15:0]      sr_q;
    logic [3:0]       fill_q;
    logic [GOOD_W-1:0] good_q;
    logic [WIN_W-1:0] win_cnt_q;
    logic [WE_W-1:0]  win_err_q;
    logic             locked_q;
    logic             err_pulse_q;
    logic [CNT_W-1:0] err_count_q;
    logic [CNT_W-1:0] bit_count_q;

    // Next bit the generator would emit, given the last 16 bits in sr_q.
    logic             pred;
    logic             mis;
    logic [15:0]      sr_rx_d;
    logic [15:0]      sr_fly_d;
    logic             win_wrap;
    logic [WE_W-1:0]  win_err_d;
    logic [CNT_W-1:0] err_count_d;
    logic [CNT_W-1:0] bit_count_d;

    assign pred     = sr_q[15] ^ sr_q[14] ^ sr_q[12] ^ sr_q[3];
    assign mis      = chk.bit_in ^ pred;
    assign sr_rx_d  = {sr_q[14:0], chk.bit_in};
    // Flywheel: in LOCKED the register feeds back its own prediction, so a
    // corrupted channel bit cannot propagate into later predictions.
    assign sr_fly_d = {sr_q[14:0], pred};

    // The bit that wraps the window opens the next one, so its own error
    // (if any) is the first error of the new window.
    assign win_wrap  = (win_cnt_q == WIN_W'(WINDOW - 1));
    assign win_err_d = win_wrap ? WE_W'(mis) : win_err_q + WE_W'(mis);

    assign err_count_d = (err_count_q == '1) ? err_count_q : err_count_q + CNT_W'(1);
    assign bit_count_d = (bit_count_q == '1) ? bit_count_q : bit_count_q + CNT_W'(1);

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order; the
    // later clr_cnt assignment intentionally overrides an increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_FILL;
            sr_q        <= '0;
            fill_q      <= '0;
            good_q      <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            bit_count_q <= '0;
        end else begin
            err_pulse_q <= 1'b0;
            if (chk.bit_valid) begin
                unique case (state_q)
                    S_FILL: begin
                        sr_q <= sr_rx_d;
                        if (fill_q == 4'd15) begin
                            fill_q <= '0;
                            // An all-zero register is the LFSR's lock-up state;
                            // refill instead of verifying it.
                            if (sr_rx_d != 16'h0000) begin
                                state_q <= S_VERIFY;
                                good_q  <= '0;
                            end
                        end else begin
                            fill_q <= fill_q + 4'd1;
                        end
                    end

                    S_VERIFY: begin
                        sr_q <= sr_rx_d;
                        if (!mis) begin
                            if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
                                state_q   <= S_LOCKED;
                                locked_q  <= 1'b1;
                                win_cnt_q <= '0;
                                win_err_q <= '0;
                            end else begin
                                good_q <= good_q + GOOD_W'(1);
                            end
                        end else begin
                            state_q <= S_FILL;
                            fill_q  <= '0;
                        end
                    end

                    S_LOCKED: begin
                        sr_q        <= sr_fly_d;
                        bit_count_q <= bit_count_d;
                        win_cnt_q   <= win_wrap ? '0 : win_cnt_q + WIN_W'(1);
                        win_err_q   <= win_err_d;
                        if (mis) begin
                            err_pulse_q <= 1'b1;
                            err_count_q <= err_count_d;
                            if (win_err_d == WE_W'(LOSS_THRESH)) begin
                                state_q  <= S_FILL;
                                fill_q   <= '0;
                                locked_q <= 1'b0;
                            end
                        end
                    end

                    default: begin
                        // Unused encoding: recover by re-acquiring.
                        state_q  <= S_FILL;
                        fill_q   <= '0;
                        locked_q <= 1'b0;
                    end
                endcase
            end
            if (chk.clr_cnt) begin
                err_count_q <= '0;
                bit_count_q <= '0;
            end
        end
    end

    assign chk.locked    = locked_q;
    assign chk.err_pulse = err_pulse_q;
    assign chk.err_count = err_count_q;
    assign chk.bit_count = bit_count_q;
    assign chk.state_out = state_q;

endmodule
